// File: rtl/seq_pkg.sv
`default_nettype none
// seq_pkg: shared width default, shifter state encoding and head-bit helper.
// Revision 1.0
package seq_pkg;

  localparam int SEQ_WIDTH = 8;
  localparam int MAX_WIDTH = 32;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT
  } state_t;

  // Bit that goes on the wire next, given the transmit order.
  function automatic logic head_bit(input logic [MAX_WIDTH-1:0] word,
                                    input int                   width,
                                    input logic                 msb_first);
    logic [4:0] idx;
    idx = 5'(width - 1);
    return msb_first ? word[idx] : word[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_hold_buf.sv
`default_nettype none
// seq_hold_buf: one-entry valid/ready holding register in front of the shifter.
// Revision 1.0
module seq_hold_buf
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  input  logic             direct,
  input  logic             drain,
  output logic             data_ready,
  output logic             accept,
  output logic [WIDTH-1:0] hold_reg,
  output logic             hold_full
);

  logic load;

  assign data_ready = reset & ~hold_full;
  assign accept     = data_valid & data_ready;
  assign load       = accept & ~direct;

  // A refill on the same edge as a drain keeps the entry occupied.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_full <= 1'b0;
      hold_reg  <= '0;
    end else if (load) begin
      hold_full <= 1'b1;
      hold_reg  <= data_in;
    end else if (drain) begin
      hold_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_serializer.sv
`default_nettype none
// seq_serializer: parallel-to-serial front end with a one-word holding buffer.
// Revision 1.0
module seq_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH     = SEQ_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             word_start,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_reg, shift_nx, shifted;
  logic [CNT_W-1:0] bit_cnt, cnt_nx;
  logic [WIDTH-1:0] hold_reg;
  logic             hold_full, accept, direct, drain, active, last;

  assign active = (state == ST_SHIFT);
  assign last   = (bit_cnt == CNT_W'(WIDTH - 1));
  // An accepted word bypasses the buffer when the shifter is free on the next edge.
  assign direct = ~active | (last & ~hold_full);

  seq_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .data_valid (data_valid),
    .direct     (direct),
    .drain      (drain),
    .data_ready (data_ready),
    .accept     (accept),
    .hold_reg   (hold_reg),
    .hold_full  (hold_full)
  );

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shift_reg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb_first
      assign shifted = {1'b0, shift_reg[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      state     <= state_nx;
      shift_reg <= shift_nx;
      bit_cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    shift_nx = shift_reg;
    cnt_nx   = bit_cnt;
    drain    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          shift_nx = data_in;
          cnt_nx   = '0;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!last) begin
          shift_nx = shifted;
          cnt_nx   = bit_cnt + CNT_W'(1);
        end else if (hold_full) begin
          shift_nx = hold_reg;
          cnt_nx   = '0;
          drain    = 1'b1;
        end else if (accept) begin
          shift_nx = data_in;
          cnt_nx   = '0;
        end else begin
          cnt_nx   = '0;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ser_valid  = active;
  assign ser_bit    = active ? head_bit(MAX_WIDTH'(shift_reg), WIDTH, MSB_FIRST) : IDLE_BIT;
  assign word_start = active & (bit_cnt == '0);
  assign busy       = active | hold_full;

endmodule
`default_nettype wire

// File: tb/tb_seq_serializer.sv
`default_nettype none
// tb_seq_serializer: directed self-checking bench for seq_serializer.
module tb_seq_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         data_valid = 1'b0;
  logic [W-1:0] data_in_l = '0;
  logic         data_valid_l = 1'b0;
  logic         data_ready, ser_bit, ser_valid, word_start, busy;
  logic         data_ready_l, ser_bit_l, ser_valid_l, word_start_l, busy_l;
  int           checks = 0;
  int           passed = 0;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_bit(ser_bit), .ser_valid(ser_valid),
    .word_start(word_start), .busy(busy)
  );

  seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in_l), .data_valid(data_valid_l),
    .data_ready(data_ready_l), .ser_bit(ser_bit_l), .ser_valid(ser_valid_l),
    .word_start(word_start_l), .busy(busy_l)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (ser_valid !== 1'b0) $display("FAIL rst_ser_valid: got %b want 0", ser_valid); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else passed++;
    checks++; if (ser_bit !== 1'b0) $display("FAIL rst_ser_bit: got %b want 0", ser_bit); else passed++;
    checks++; if (word_start !== 1'b0) $display("FAIL rst_word_start: got %b want 0", word_start); else passed++;
    checks++; if (data_ready !== 1'b0) $display("FAIL rst_data_ready: got %b want 0", data_ready); else passed++;
    checks++; if (ser_bit_l !== 1'b1) $display("FAIL rst_idle_bit_lsb: got %b want 1", ser_bit_l); else passed++;
    reset = 1'b1;
    tick();
    checks++; if (data_ready !== 1'b1) $display("FAIL rel_data_ready: got %b want 1", data_ready); else passed++;
    checks++; if (ser_valid !== 1'b0) $display("FAIL rel_ser_valid: got %b want 0", ser_valid); else passed++;
  endtask

  task automatic test_msb_single;
    logic [7:0] v, b, s;
    v = '0; b = '0; s = '0;
    data_in = 8'hB0; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      v = {v[6:0], ser_valid}; b = {b[6:0], ser_bit}; s = {s[6:0], word_start};
      tick();
    end
    checks++; if (b !== 8'hB0) $display("FAIL msb_bits: got %h want b0", b); else passed++;
    checks++; if (v !== 8'hFF) $display("FAIL msb_valid: got %h want ff", v); else passed++;
    checks++; if (s !== 8'h80) $display("FAIL msb_word_start: got %h want 80", s); else passed++;
    checks++; if ({ser_valid, ser_bit, busy} !== 3'b000) $display("FAIL msb_after: got %b want 000", {ser_valid, ser_bit, busy}); else passed++;
  endtask

  task automatic test_lsb_single;
    logic [7:0] v, b, s;
    v = '0; b = '0; s = '0;
    data_in_l = 8'h0D; data_valid_l = 1'b1;
    tick();
    data_valid_l = 1'b0;
    for (int c = 0; c < 8; c++) begin
      v = {v[6:0], ser_valid_l}; b = {b[6:0], ser_bit_l}; s = {s[6:0], word_start_l};
      tick();
    end
    checks++; if (b !== 8'b1011_0000) $display("FAIL lsb_bits: got %b want 10110000", b); else passed++;
    checks++; if (v !== 8'hFF) $display("FAIL lsb_valid: got %h want ff", v); else passed++;
    checks++; if (s !== 8'h80) $display("FAIL lsb_word_start: got %h want 80", s); else passed++;
    checks++; if ({ser_valid_l, ser_bit_l, busy_l} !== 3'b010) $display("FAIL lsb_after: got %b want 010", {ser_valid_l, ser_bit_l, busy_l}); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] v, b, s;
    logic        rdy, bsy;
    v = '0; b = '0; s = '0; rdy = 1'b1; bsy = 1'b0;
    data_in = 8'hA5; data_valid = 1'b1;
    tick();
    data_in = 8'h3C;
    for (int c = 0; c < 16; c++) begin
      v = {v[14:0], ser_valid}; b = {b[14:0], ser_bit}; s = {s[14:0], word_start};
      if (c == 1) begin
        rdy = data_ready; bsy = busy; data_valid = 1'b0;
      end
      tick();
    end
    checks++; if (b !== 16'hA53C) $display("FAIL b2b_bits: got %h want a53c", b); else passed++;
    checks++; if (v !== 16'hFFFF) $display("FAIL b2b_valid: got %h want ffff", v); else passed++;
    checks++; if (s !== 16'h8080) $display("FAIL b2b_word_start: got %h want 8080", s); else passed++;
    checks++; if (rdy !== 1'b0) $display("FAIL b2b_ready_held: got %b want 0", rdy); else passed++;
    checks++; if (bsy !== 1'b1) $display("FAIL b2b_busy_held: got %b want 1", bsy); else passed++;
    checks++; if ({ser_valid, busy} !== 2'b00) $display("FAIL b2b_after: got %b want 00", {ser_valid, busy}); else passed++;
  endtask

  task automatic test_backpressure;
    logic [23:0] v, b, s, r;
    logic [7:0]  words [3];
    int          idx, acc;
    logic        go;
    words = '{8'hC3, 8'h5A, 8'hF0};
    v = '0; b = '0; s = '0; r = '0;
    data_in = words[0]; data_valid = 1'b1;
    tick();
    idx = 1; acc = 1; data_in = words[1];
    for (int c = 0; c < 24; c++) begin
      v = {v[22:0], ser_valid}; b = {b[22:0], ser_bit};
      s = {s[22:0], word_start}; r = {r[22:0], data_ready};
      go = data_valid & data_ready;
      tick();
      if (go) begin
        acc++; idx++;
        if (idx < 3) data_in = words[idx];
        else data_valid = 1'b0;
      end
    end
    checks++; if (b !== 24'hC35AF0) $display("FAIL bp_bits: got %h want c35af0", b); else passed++;
    checks++; if (v !== 24'hFFFFFF) $display("FAIL bp_valid: got %h want ffffff", v); else passed++;
    checks++; if (s !== 24'h808080) $display("FAIL bp_word_start: got %h want 808080", s); else passed++;
    checks++; if (r !== 24'h8080FF) $display("FAIL bp_ready: got %h want 8080ff", r); else passed++;
    checks++; if (acc !== 3) $display("FAIL bp_accepts: got %0d want 3", acc); else passed++;
    checks++; if (ser_valid !== 1'b0) $display("FAIL bp_after: got %b want 0", ser_valid); else passed++;
  endtask

  task automatic test_last_bit;
    logic [15:0] v, b, s, r;
    v = '0; b = '0; s = '0; r = '0;
    data_in = 8'hFF; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < 16; c++) begin
      v = {v[14:0], ser_valid}; b = {b[14:0], ser_bit};
      s = {s[14:0], word_start}; r = {r[14:0], data_ready};
      if (c == 7) begin
        data_in = 8'h00; data_valid = 1'b1;
      end
      if (c == 8) data_valid = 1'b0;
      tick();
    end
    checks++; if (b !== 16'hFF00) $display("FAIL lb_bits: got %h want ff00", b); else passed++;
    checks++; if (v !== 16'hFFFF) $display("FAIL lb_valid: got %h want ffff", v); else passed++;
    checks++; if (s !== 16'h8080) $display("FAIL lb_word_start: got %h want 8080", s); else passed++;
    checks++; if (r !== 16'hFFFF) $display("FAIL lb_ready: got %h want ffff", r); else passed++;
    checks++; if (ser_valid !== 1'b0) $display("FAIL lb_after: got %b want 0", ser_valid); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [7:0] v, b, s;
    logic [3:0] q;
    data_in = 8'hB0; data_valid = 1'b1;
    tick();
    data_in = 8'h55;
    tick();
    data_valid = 1'b0;
    checks++; if ({busy, data_ready} !== 2'b10) $display("FAIL rm_held: got %b want 10", {busy, data_ready}); else passed++;
    tick();
    tick();
    checks++; if (ser_bit !== 1'b1) $display("FAIL rm_bit4: got %b want 1", ser_bit); else passed++;
    reset = 1'b0;
    data_in = 8'hFF; data_valid = 1'b1;
    checks++; if (data_ready !== 1'b0) $display("FAIL rm_ready_in_reset: got %b want 0", data_ready); else passed++;
    tick();
    checks++; if ({ser_valid, busy, data_ready, ser_bit} !== 4'b0000) $display("FAIL rm_reset: got %b want 0000", {ser_valid, busy, data_ready, ser_bit}); else passed++;
    tick();
    checks++; if ({ser_valid, busy} !== 2'b00) $display("FAIL rm_ignore_valid: got %b want 00", {ser_valid, busy}); else passed++;
    data_valid = 1'b0;
    reset = 1'b1;
    q = '0;
    for (int c = 0; c < 4; c++) begin
      tick();
      q = {q[2:0], ser_valid};
    end
    checks++; if (data_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", data_ready); else passed++;
    checks++; if (q !== 4'b0000) $display("FAIL rm_hold_discarded: got %b want 0000", q); else passed++;
    v = '0; b = '0; s = '0;
    data_in = 8'h96; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      v = {v[6:0], ser_valid}; b = {b[6:0], ser_bit}; s = {s[6:0], word_start};
      tick();
    end
    checks++; if (b !== 8'h96) $display("FAIL rm_fresh_bits: got %h want 96", b); else passed++;
    checks++; if (v !== 8'hFF) $display("FAIL rm_fresh_valid: got %h want ff", v); else passed++;
    checks++; if (s !== 8'h80) $display("FAIL rm_fresh_word_start: got %h want 80", s); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_msb_single();
    test_lsb_single();
    test_back_to_back();
    test_backpressure();
    test_last_bit();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
